// File: rtl/bp_be_dcache_req_arbiter_if.sv
// Handshake bundle shared by the requesters, the dcache request arbiter and
// the dcache/TLB side. Signal names are seen from the arbiter's point of view.
interface bp_be_dcache_req_arbiter_if
   #(parameter int num_req_p    = 2,
     parameter int pkt_width_p  = 32,
     parameter int ptag_width_p = 28,
     parameter int data_width_p = 64)
   ();

   logic [num_req_p*pkt_width_p-1:0]  pkt_i;
   logic [num_req_p*ptag_width_p-1:0] ptag_i;
   logic [num_req_p-1:0]              v_i;
   logic [num_req_p-1:0]              ready_o;
   logic [num_req_p-1:0]              v_o;
   logic [data_width_p-1:0]           data_o;
   logic [pkt_width_p-1:0]            dcache_pkt_o;
   logic                              dcache_v_o;
   logic                              dcache_ready_i;
   logic [ptag_width_p-1:0]           dcache_ptag_o;
   logic                              dcache_v_i;
   logic [data_width_p-1:0]           dcache_data_i;
   logic                              cache_miss_i;

   // Arbiter side of the bundle
   modport slave (
      input  pkt_i, ptag_i, v_i, dcache_ready_i, dcache_v_i, dcache_data_i, cache_miss_i,
      output ready_o, v_o, data_o, dcache_pkt_o, dcache_v_o, dcache_ptag_o
   );

   // Environment side (requesters plus dcache)
   modport master (
      output pkt_i, ptag_i, v_i, dcache_ready_i, dcache_v_i, dcache_data_i, cache_miss_i,
      input  ready_o, v_o, data_o, dcache_pkt_o, dcache_v_o, dcache_ptag_o
   );

endinterface

// File: rtl/bp_be_dcache_req_arbiter.sv
// Round-robin arbiter sharing one dcache request port among several
// requesters. Every granted request is remembered in a small circular buffer
// so its response can be steered back to the requester that issued it, and so
// that after a dcache miss the squashed requests can be replayed in their
// original order before any new request is granted.
module bp_be_dcache_req_arbiter
   #(parameter int num_req_p    = 2,
     parameter int pkt_width_p  = 32,
     parameter int ptag_width_p = 28,
     parameter int data_width_p = 64,
     parameter int els_p        = 4)
   (input logic                     clk_i,
    input logic                     reset_i,
    bp_be_dcache_req_arbiter_if.slave arb_if);

   localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w = $clog2(els_p + 1);

   typedef enum logic {NORMAL, REPLAY} state_e;

   // Registered state
   state_e             state_q, state_d;
   logic [ptr_w-1:0]   head_q, head_d;
   logic [ptr_w-1:0]   tail_q, tail_d;
   logic [ptr_w-1:0]   rp_q, rp_d;
   logic [cnt_w-1:0]   count_q, count_d;
   logic [cnt_w-1:0]   pending_q, pending_d;
   logic [id_w-1:0]    rrPtr_q, rrPtr_d;
   logic [ptag_width_p-1:0] ptagOut_q, ptagOut_d;

   // In-flight / replay storage
   logic [id_w-1:0]         id_q   [els_p];
   logic [pkt_width_p-1:0]  pkt_q  [els_p];
   logic [ptag_width_p-1:0] ptag_q [els_p];

   // Per-requester views of the flattened request buses
   logic [pkt_width_p-1:0]  reqPkt  [num_req_p];
   logic [ptag_width_p-1:0] reqPtag [num_req_p];

   // Combinational control
   logic              winnerFound;
   logic [id_w-1:0]   winnerIdx;
   logic [id_w-1:0]   candIdx;
   int                scanIdx;
   logic              bufFull;
   logic              missNow;
   logic              retire;
   logic              issueOk;
   logic              replayValid;
   logic              newAccept;
   logic              replayAccept;
   logic [num_req_p-1:0]    readyVec;
   logic [num_req_p-1:0]    respVec;
   logic [pkt_width_p-1:0]  issuePkt;
   logic [data_width_p-1:0] respData;

   function automatic logic [ptr_w-1:0] ptrInc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
      assign reqPkt[g]  = arb_if.pkt_i[g*pkt_width_p +: pkt_width_p];
      assign reqPtag[g] = arb_if.ptag_i[g*ptag_width_p +: ptag_width_p];
   end

   // Pick the first valid requester after the last winner, wrapping around
   always_comb begin
      winnerFound = 1'b0;
      winnerIdx   = '0;
      candIdx     = '0;
      scanIdx     = 0;
      for (int k = 1; k <= num_req_p; k++) begin
         scanIdx = (int'(rrPtr_q) + k) % num_req_p;
         candIdx = id_w'(scanIdx);
         if (!winnerFound && arb_if.v_i[candIdx]) begin
            winnerFound = 1'b1;
            winnerIdx   = candIdx;
         end
      end
   end

   // Decide what may issue, retire or be replayed this cycle
   always_comb begin
      bufFull      = (count_q == cnt_w'(els_p));
      missNow      = arb_if.cache_miss_i;
      retire       = arb_if.dcache_v_i & ~missNow & (count_q != '0) & ~reset_i;
      issueOk      = (state_q == NORMAL) & ~bufFull & ~missNow & ~reset_i;
      replayValid  = (state_q == REPLAY) & (pending_q != '0) & ~missNow & ~reset_i;
      newAccept    = issueOk & winnerFound & arb_if.dcache_ready_i;
      replayAccept = replayValid & arb_if.dcache_ready_i;
   end

   // Build the requester-facing grant/response vectors and the dcache packet
   always_comb begin
      readyVec = '0;
      respVec  = '0;
      issuePkt = reqPkt[winnerIdx];
      respData = arb_if.dcache_data_i;
      if (newAccept) begin
         readyVec[winnerIdx] = 1'b1;
      end
      if (retire) begin
         respVec[id_q[head_q]] = 1'b1;
      end
      if (state_q == REPLAY) begin
         issuePkt = pkt_q[rp_q];
      end
   end

   assign arb_if.ready_o       = readyVec;
   assign arb_if.v_o           = respVec;
   assign arb_if.data_o        = respData;
   assign arb_if.dcache_pkt_o  = issuePkt;
   assign arb_if.dcache_v_o    = (issueOk & winnerFound) | replayValid;
   assign arb_if.dcache_ptag_o = ptagOut_q;

   // Next-state for pointers, occupancy, round-robin and the replay sequencer
   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      rp_d      = rp_q;
      pending_d = pending_q;
      rrPtr_d   = rrPtr_q;
      ptagOut_d = ptagOut_q;
      count_d   = count_q + cnt_w'(newAccept) - cnt_w'(retire);
      if (retire) begin
         head_d = ptrInc(head_q);
      end
      if (newAccept) begin
         tail_d    = ptrInc(tail_q);
         rp_d      = ptrInc(tail_q);
         rrPtr_d   = winnerIdx;
         ptagOut_d = reqPtag[winnerIdx];
      end
      if (replayAccept) begin
         rp_d      = ptrInc(rp_q);
         pending_d = pending_q - 1'b1;
         ptagOut_d = ptag_q[rp_q];
      end
      if (missNow) begin
         rp_d      = head_q;
         pending_d = count_q;
         state_d   = REPLAY;
      end else if ((state_q == REPLAY) && (pending_d == '0)) begin
         state_d = NORMAL;
      end
   end

   // Control registers with synchronous reset; reset drops all in-flight entries
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= NORMAL;
         head_q    <= '0;
         tail_q    <= '0;
         rp_q      <= '0;
         count_q   <= '0;
         pending_q <= '0;
         rrPtr_q   <= id_w'(num_req_p - 1);
         ptagOut_q <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         rp_q      <= rp_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         rrPtr_q   <= rrPtr_d;
         ptagOut_q <= ptagOut_d;
      end
   end

   // Capture each newly granted request at the tail of the buffer
   always_ff @(posedge clk_i) begin
      if (newAccept) begin
         id_q[tail_q]   <= winnerIdx;
         pkt_q[tail_q]  <= reqPkt[winnerIdx];
         ptag_q[tail_q] <= reqPtag[winnerIdx];
      end
   end

   // A result and a miss in the same cycle is an illegal dcache behaviour
   a_no_hit_and_miss: assert property (@(posedge clk_i) disable iff (reset_i)
      !(arb_if.dcache_v_i && arb_if.cache_miss_i));

   // A result can only arrive for a request that is still in flight
   a_no_hit_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
      !(arb_if.dcache_v_i && (count_q == '0)));

endmodule

// File: doc/bp_be_dcache_req_arbiter.md
# bp_be_dcache_req_arbiter

Round-robin arbiter and replay sequencer that shares one `bp_be_dcache` request port among `num_req_p` requesters. It sits between requester-side packet sources and the dcache (plus mock TLB ptag path). It tracks every in-flight request so each response returns to the requester that issued it. On a dcache miss it replays the squashed in-flight requests in original order before it grants anything new.

## Interface
- `num_req_p`, 2: number of requesters; ≥1.
- `pkt_width_p`, "inv": width of `bp_be_dcache_pkt_s`.
- `ptag_width_p`, "inv": physical tag width.
- `data_width_p`, 64: dcache load data width.
- `els_p`, 4: in-flight/replay buffer depth; ≥3 (covers dcache 2-cycle pipe plus 1 slack).

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `pkt_i` in `num_req_p*pkt_width_p`: per-requester dcache packet.
- `ptag_i` in `num_req_p*ptag_width_p`: per-requester ptag, same cycle as pkt.
- `v_i` in `num_req_p`: request valid.
- `ready_o` out `num_req_p`: one-hot grant; handshake = `v_i[i] & ready_o[i]`.
- `v_o` out `num_req_p`: response valid, one-hot.
- `data_o` out `data_width_p`: response data, shared by all requesters.
- `dcache_pkt_o` out `pkt_width_p`: packet to dcache.
- `dcache_v_o` out 1: packet valid.
- `dcache_ready_i` in 1: dcache ready.
- `dcache_ptag_o` out `ptag_width_p`: ptag of the packet accepted the previous cycle.
- `dcache_v_i` in 1: dcache result valid (head request done).
- `dcache_data_i` in `data_width_p`: dcache result data.
- `cache_miss_i` in 1: dcache miss; squashes all in-flight requests.

## Operation
- Buffer: circular FIFO of `els_p` entries {req id, pkt, ptag}. Head = oldest unretired. Tail = next free. Replay pointer `rp` lies between head and tail. Count width `clog2(els_p+1)`.
- States: NORMAL, REPLAY. Reset → NORMAL, buffer empty, rr pointer = `num_req_p-1` so requester 0 has priority first.
- NORMAL issue: permitted when buffer not full and `cache_miss_i`=0.
  - Winner = first `v_i` set, scanning from rr+1 with wrap.
  - `dcache_pkt_o` = winner pkt; `dcache_v_o` = any `v_i` & permitted.
  - `ready_o[winner]` = permitted & `dcache_ready_i`.
  - On accept: push entry at tail, rr ← winner, `rp` ← tail+1.
- `dcache_ptag_o`: register loaded with the ptag of the issued entry on each accept (new or replay). Holds otherwise.
- Retire: `dcache_v_i` → `v_o[head.id]`=1, `data_o`=`dcache_data_i`, head advances. Store packets also retire this way; requesters ignore the data.
- Miss: `cache_miss_i` → `rp` ← head and state → REPLAY, even if `rp` already = head. No issue in the miss cycle (`dcache_v_o`=0).
- REPLAY:
  - `ready_o` all 0; `dcache_pkt_o` = entry[`rp`].pkt; `dcache_v_o`=1 while `rp`≠tail.
  - On `dcache_ready_i`: `rp`++ and ptag register loads entry[`rp`].ptag.
  - When `rp` = tail → NORMAL.
  - A miss during REPLAY restarts from head.
  - Retirements during REPLAY are legal.
- `dcache_v_i` & `cache_miss_i` in the same cycle is illegal: assertion fires, miss takes precedence, no retire.
- `dcache_v_i` with an empty buffer is illegal: assertion fires, no state change.
- Reset mid-operation drops all entries; no responses are produced for them.

## Timing
- Outputs under reset: `ready_o`=0, `v_o`=0, `dcache_v_o`=0, `dcache_ptag_o`=0, `data_o`=`dcache_data_i` passthrough.
- Request path is combinational: `v_i` → `dcache_v_o`/`dcache_pkt_o`/`ready_o` in the same cycle. Grant also depends on `dcache_ready_i`.
- `dcache_ptag_o` valid at accept+1, matching the dcache TLB stage.
- Response path is combinational: `dcache_v_i` → `v_o` in the same cycle, so zero added latency. Requester sees a hit at accept+2.
- Buffer full with a retire in the same cycle: no grant that cycle. Full status is evaluated from registered count.
- Replay rate: 1 entry per cycle while `dcache_ready_i`=1.

## Test plan
- Single requester, 3 back-to-back loads to hits 0x80, 0x88, 0x90 → `v_o[0]` at cycles t+2, t+3, t+4 with matching data; `ready_o[0]`=1 every cycle.
- Two requesters always valid → grants alternate 0,1,0,1 starting with 0 after reset. Each `v_o[i]` matches its own packet's data.
- Req0 load miss while req1's load is in flight → next cycle `dcache_v_o`=0. Then REPLAY re-issues req0, then req1, in order with `ready_o`=0. Responses arrive req0 first, then req1, with correct data. `v_i[0]` pending during REPLAY gets no grant.
- Second miss mid-replay → `rp` returns to head and the replay sequence restarts. No duplicate `v_o` pulses.
- `dcache_ready_i` low and `els_p`=4 full → `ready_o`=0. After 1 retire, exactly one new grant.
- Assert `reset_i` with 2 entries in flight → next cycle all outputs are at reset values. A late `dcache_v_i` triggers the empty-buffer assertion and produces no `v_o`.
